// File: rtl/dfh_list_walker.sv
// dfh_list_walker
//   Avalon-MM read initiator that walks a DFHv1 feature chain. Each feature
//   costs three single-beat reads (header, GUID_L, GUID_H); a one-cycle
//   feature record is then emitted and the walk follows next_dfh until EOL
//   or until an error is detected.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   start, base_addr    walk launch pulse (honoured only when idle) and first DFH address
//   avmm_*              AVMM read master (one read outstanding at a time)
//   busy, done          walk in progress / one-cycle end-of-walk pulse
//   error, err_code     sticky error and its cause, cleared by the next start
//                       (1 misaligned, 2 timeout, 3 next=0 w/o EOL, 4 overflow, 5 too many)
//   feat_*              feature record; feat_valid strobes, the rest hold until the next record
module dfh_list_walker #(
    parameter int ADDR_WIDTH     = 20,
    parameter int MAX_FEATURES   = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic [ADDR_WIDTH-1:0] avmm_address,
    output logic                  avmm_read,
    input  logic                  avmm_waitrequest,
    input  logic [63:0]           avmm_readdata,
    input  logic                  avmm_readdatavalid,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            err_code,
    output logic                  feat_valid,
    output logic [ADDR_WIDTH-1:0] feat_addr,
    output logic [11:0]           feat_id,
    output logic [3:0]            feat_rev,
    output logic [3:0]            feat_type,
    output logic [127:0]          feat_guid,
    output logic [7:0]            feat_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // Wide enough to hold cur_addr + 24-bit offset without losing the carry.
    localparam int SW = ((ADDR_WIDTH > 24) ? ADDR_WIDTH : 24) + 1;

    typedef enum logic [3:0] {
        IDLE, REQ_HDR, WAIT_HDR, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, EMIT, FINISH
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [TW-1:0]         timer;
    logic [11:0]           hdr_id;
    logic [3:0]            hdr_rev;
    logic [3:0]            hdr_type;
    logic [23:0]           next_off;
    logic                  eol;
    logic [63:0]           guid_lo;
    logic                  err_set;
    logic [2:0]            err_nxt;
    logic                  accept, timeout, waiting, overflow;
    logic [SW-1:0]         next_sum;
    logic [ADDR_WIDTH-1:0] req_off, req_addr;

    assign accept   = avmm_read && !avmm_waitrequest;
    assign waiting  = state inside {WAIT_HDR, WAIT_LO, WAIT_HI};
    assign timeout  = (timer == TW'(TIMEOUT_CYCLES - 1));
    assign next_sum = SW'(cur_addr) + SW'(next_off);
    assign overflow = |next_sum[SW-1:ADDR_WIDTH];

    always_comb begin
        req_off = '0;
        case (state)
            REQ_LO:  req_off = ADDR_WIDTH'(8);
            REQ_HI:  req_off = ADDR_WIDTH'(16);
            default: req_off = '0;
        endcase
    end

    // The low three bits are forced to zero so the bus address stays
    // qword aligned even if a chain supplies an odd next offset.
    assign req_addr     = cur_addr + req_off;
    assign avmm_address = avmm_read ? (req_addr & ~ADDR_WIDTH'(7)) : '0;
    assign avmm_read    = state inside {REQ_HDR, REQ_LO, REQ_HI};
    assign busy         = !(state inside {IDLE, FINISH});
    assign done         = (state == FINISH);
    assign feat_valid   = (state == EMIT);

    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        err_nxt   = 3'd0;
        case (state)
            IDLE: if (start) begin
                if (|base_addr[2:0]) begin
                    err_set   = 1'b1;
                    err_nxt   = 3'd1;
                    state_nxt = FINISH;
                end else begin
                    state_nxt = REQ_HDR;
                end
            end
            REQ_HDR: if (accept) state_nxt = WAIT_HDR;
            REQ_LO:  if (accept) state_nxt = WAIT_LO;
            REQ_HI:  if (accept) state_nxt = WAIT_HI;
            WAIT_HDR, WAIT_LO, WAIT_HI: begin
                if (avmm_readdatavalid) begin
                    state_nxt = (state == WAIT_HDR) ? REQ_LO :
                                (state == WAIT_LO)  ? REQ_HI : EMIT;
                end else if (timeout) begin
                    err_set   = 1'b1;
                    err_nxt   = 3'd2;
                    state_nxt = FINISH;
                end
            end
            EMIT: begin
                state_nxt = FINISH;
                if (eol) begin
                    state_nxt = FINISH;
                end else if (next_off == 24'd0) begin
                    err_set = 1'b1;
                    err_nxt = 3'd3;
                end else if (overflow) begin
                    err_set = 1'b1;
                    err_nxt = 3'd4;
                end else if (feat_count == 8'(MAX_FEATURES)) begin
                    err_set = 1'b1;
                    err_nxt = 3'd5;
                end else begin
                    state_nxt = REQ_HDR;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cur_addr   <= '0;
            timer      <= '0;
            hdr_id     <= '0;
            hdr_rev    <= '0;
            hdr_type   <= '0;
            next_off   <= '0;
            eol        <= 1'b0;
            guid_lo    <= '0;
            error      <= 1'b0;
            err_code   <= '0;
            feat_count <= '0;
            feat_addr  <= '0;
            feat_id    <= '0;
            feat_rev   <= '0;
            feat_type  <= '0;
            feat_guid  <= '0;
        end else begin
            state <= state_nxt;
            if (accept)       timer <= '0;
            else if (waiting) timer <= timer + TW'(1);
            case (state)
                IDLE: if (start) begin
                    error      <= 1'b0;
                    err_code   <= '0;
                    feat_count <= '0;
                    cur_addr   <= base_addr;
                end
                WAIT_HDR: if (avmm_readdatavalid) begin
                    hdr_id   <= avmm_readdata[11:0];
                    hdr_rev  <= avmm_readdata[15:12];
                    next_off <= avmm_readdata[39:16];
                    eol      <= avmm_readdata[40];
                    hdr_type <= avmm_readdata[63:60];
                end
                WAIT_LO: if (avmm_readdatavalid) guid_lo <= avmm_readdata;
                // Record registers load on entry to EMIT so they are valid
                // alongside the strobe and then hold.
                WAIT_HI: if (avmm_readdatavalid) begin
                    feat_addr <= cur_addr;
                    feat_id   <= hdr_id;
                    feat_rev  <= hdr_rev;
                    feat_type <= hdr_type;
                    feat_guid <= {avmm_readdata, guid_lo};
                    if (feat_count != 8'hFF) feat_count <= feat_count + 8'd1;
                end
                EMIT: if (state_nxt == REQ_HDR) cur_addr <= next_sum[ADDR_WIDTH-1:0];
                default: ;
            endcase
            // Placed after the start-clear so a misaligned base still flags.
            if (err_set) begin
                error    <= 1'b1;
                err_code <= err_nxt;
            end
        end
    end

endmodule

// File: tb/tb_dfh_list_walker.sv
module tb_dfh_list_walker;
    localparam int AW   = 20;
    localparam int MAXF = 4;
    localparam int TO   = 64;

    logic          clk = 0;
    logic          reset_n = 0;
    logic          start = 0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] avmm_address;
    logic          avmm_read;
    logic          avmm_waitrequest = 0;
    logic [63:0]   avmm_readdata = '0;
    logic          avmm_readdatavalid = 0;
    logic          busy, done, error, feat_valid;
    logic [2:0]    err_code;
    logic [AW-1:0] feat_addr;
    logic [11:0]   feat_id;
    logic [3:0]    feat_rev, feat_type;
    logic [127:0]  feat_guid;
    logic [7:0]    feat_count;

    dfh_list_walker #(.ADDR_WIDTH(AW), .MAX_FEATURES(MAXF), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .avmm_address(avmm_address), .avmm_read(avmm_read),
        .avmm_waitrequest(avmm_waitrequest), .avmm_readdata(avmm_readdata),
        .avmm_readdatavalid(avmm_readdatavalid), .busy(busy), .done(done),
        .error(error), .err_code(err_code), .feat_valid(feat_valid),
        .feat_addr(feat_addr), .feat_id(feat_id), .feat_rev(feat_rev),
        .feat_type(feat_type), .feat_guid(feat_guid), .feat_count(feat_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // ---------------- memory image and behavioural model ----------------
    logic [63:0] mem [int unsigned];

    function automatic logic [63:0] rd(input int unsigned a);
        if (mem.exists(a)) return mem[a];
        return 64'h0;
    endfunction

    function automatic logic [63:0] hdr(input logic [3:0] ty, input logic e, input logic [23:0] nxt,
                                        input logic [3:0] rev, input logic [11:0] id);
        return {ty, 19'b0, e, nxt, rev, id};
    endfunction

    typedef struct {
        int unsigned addr;
        logic [11:0]  id;
        logic [3:0]   rev;
        logic [3:0]   ty;
        logic [127:0] guid;
        int           cnt;
    } rec_t;

    rec_t        exp_q[$];
    int          exp_code = 0;
    int          exp_n = 0;
    bit          drop_en = 0;
    int unsigned drop_addr = 0;

    // Walk the chain in the memory image directly, feature by feature.
    task automatic model_walk(input int unsigned base);
        int unsigned a;
        logic [63:0] h;
        int n;
        rec_t r;
        exp_q.delete();
        n = 0;
        a = base;
        exp_code = 0;
        if (base % 8 != 0) exp_code = 1;
        else begin
            while (1) begin
                if (drop_en && (drop_addr == a || drop_addr == a + 8 || drop_addr == a + 16)) begin
                    exp_code = 2; break;
                end
                h = rd(a);
                n++;
                r.addr = a; r.id = h[11:0]; r.rev = h[15:12]; r.ty = h[63:60];
                r.guid = {rd(a + 16), rd(a + 8)};
                r.cnt  = (n > 255) ? 255 : n;
                exp_q.push_back(r);
                if (h[40]) break;
                if (h[39:16] == 0) begin exp_code = 3; break; end
                if (a + h[39:16] >= (1 << AW)) begin exp_code = 4; break; end
                if (n == MAXF) begin exp_code = 5; break; end
                a = a + h[39:16];
            end
        end
        exp_n = n;
    endtask

    // ---------------- responder + compare (on falling edge) ----------------
    int          wait_cfg = 0;
    int          lat = 1;
    int          stall_cnt = 0;
    bit          pend = 0;
    int          pend_cnt = 0;
    int unsigned pend_addr = 0;
    int          accepted = 0;
    int          read_cycles = 0;
    int unsigned last_acc = 0;
    int          done_cnt = 0;
    bit          prev_stall = 0;
    logic [AW-1:0] prev_addr = '0;

    always @(negedge clk) begin
        rec_t r;
        if (feat_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_feat: got record at %0h expected none", feat_addr);
            end else begin
                r = exp_q.pop_front();
                chk("feat_addr", feat_addr, r.addr);
                chk("feat_id", feat_id, r.id);
                chk("feat_rev", feat_rev, r.rev);
                chk("feat_type", feat_type, r.ty);
                chk("feat_guid", feat_guid, r.guid);
                chk("feat_count_emit", feat_count, r.cnt);
            end
        end
        if (done) begin
            done_cnt++;
            chk("done_error", error, exp_code != 0);
            chk("done_err_code", err_code, exp_code);
            chk("done_recs_left", exp_q.size(), 0);
            chk("done_feat_count", feat_count, exp_n);
            chk("done_busy", busy, 0);
        end
        if (prev_stall) begin
            chk("stall_read", avmm_read, 1);
            chk("stall_addr", avmm_address, prev_addr);
        end
        avmm_readdatavalid = 0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                avmm_readdatavalid = 1;
                avmm_readdata = rd(pend_addr);
                pend = 0;
            end
        end
        if (avmm_read) begin
            read_cycles++;
            chk("addr_align", avmm_address[2:0], 0);
            if (stall_cnt < wait_cfg) begin
                avmm_waitrequest = 1;
                stall_cnt++;
            end else begin
                avmm_waitrequest = 0;
                stall_cnt = 0;
                accepted++;
                last_acc = avmm_address;
                if (!(drop_en && avmm_address == drop_addr)) begin
                    pend = 1; pend_cnt = lat; pend_addr = avmm_address;
                end
            end
        end else begin
            avmm_waitrequest = 0;
        end
        prev_stall = avmm_read && avmm_waitrequest;
        prev_addr  = avmm_address;
    end

    // Launch a walk and return the cycle (1 = first cycle after start is taken)
    // in which done was seen.
    task automatic run_walk(input int unsigned base, input int bound, output int c);
        int d0;
        model_walk(base);
        d0 = done_cnt;
        @(negedge clk); #1;
        base_addr = AW'(base); start = 1;
        @(negedge clk); #1;
        start = 0;
        c = 1;
        while (done_cnt == d0 && c < bound) begin
            @(negedge clk); #1;
            c++;
        end
        if (done_cnt == d0) begin
            checks++; errors++;
            $display("FAIL walk_timeout: got no done after %0d cycles expected done", bound);
        end
    endtask

    initial begin
        int c, a0, r0;
        // scenario 1 image: three features, 0x0 -> 0x1000 -> 0x2000 (EOL)
        mem[32'h0000] = hdr(4'h3, 0, 24'h1000, 4'h1, 12'h001);
        mem[32'h0008] = 64'h1111_0000_AAAA_0001;
        mem[32'h0010] = 64'h2222_0000_BBBB_0001;
        mem[32'h1000] = hdr(4'h3, 0, 24'h1000, 4'h2, 12'h002);
        mem[32'h1008] = 64'h1111_0000_AAAA_0002;
        mem[32'h1010] = 64'h2222_0000_BBBB_0002;
        mem[32'h2000] = hdr(4'h4, 1, 24'h0000, 4'h3, 12'h003);
        mem[32'h2008] = 64'hFFFF_FFFF_FFFF_FFFF;
        mem[32'h2010] = 64'h2222_0000_BBBB_0003;
        // next=0 without EOL
        mem[32'h5000] = hdr(4'h1, 0, 24'h0, 4'h0, 12'h055);
        // long chain for MAX_FEATURES
        for (int i = 0; i < 6; i++) mem[32'h6000 + i * 32'h40] = hdr(4'h2, 0, 24'h40, 4'h1, 12'(12'h60 + i));
        // overflow
        mem[32'hFF000] = hdr(4'h2, 0, 24'h1000, 4'h0, 12'h0FF);

        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_feat_valid", feat_valid, 0);
        chk("rst_feat_count", feat_count, 0);
        chk("rst_read", avmm_read, 0);
        reset_n = 1;

        // 1: basic chain
        run_walk(0, 200, c);
        chk("s1_latency", c, 22);
        chk("s1_count", feat_count, 3);
        chk("s1_error", error, 0);
        chk("s1_last_addr", feat_addr, 20'h2000);
        chk("s1_last_id", feat_id, 12'h003);
        chk("s1_last_guid", feat_guid, 128'h2222_0000_BBBB_0003_FFFF_FFFF_FFFF_FFFF);

        // 2: 5-cycle stalls; a start while busy must be ignored
        wait_cfg = 5;
        a0 = accepted;
        fork
            run_walk(0, 300, c);
            begin
                repeat (20) @(negedge clk);
                #2 base_addr = 20'h5000; start = 1;
                @(negedge clk);
                #2 start = 0;
            end
        join
        chk("s2_accepted", accepted - a0, 9);
        chk("s2_latency", c, 67);
        chk("s2_count", feat_count, 3);
        chk("s2_last_addr", feat_addr, 20'h2000);
        wait_cfg = 0;

        // 3: GUID_L of second feature never answered
        drop_en = 1; drop_addr = 32'h1008;
        run_walk(0, 300, c);
        chk("s3_latency", c, 75);
        chk("s3_err_code", err_code, 2);
        chk("s3_count", feat_count, 1);
        drop_en = 0;

        // 4: next=0, MAX_FEATURES, overflow
        run_walk(32'h5000, 100, c);
        chk("s4a_err_code", err_code, 3);
        chk("s4a_count", feat_count, 1);
        run_walk(32'h6000, 200, c);
        chk("s4b_err_code", err_code, 5);
        chk("s4b_count", feat_count, 4);
        chk("s4b_last_addr", feat_addr, 20'h60C0);
        run_walk(32'hFF000, 100, c);
        chk("s4c_err_code", err_code, 4);
        chk("s4c_count", feat_count, 1);

        // 5: misaligned base
        r0 = read_cycles;
        run_walk(32'h4, 20, c);
        chk("s5_latency", c, 1);
        chk("s5_err_code", err_code, 1);
        chk("s5_reads", read_cycles - r0, 0);

        // 6: reset while waiting for GUID_L, then a clean walk
        lat = 3;
        model_walk(0);
        a0 = accepted;
        @(negedge clk); #1;
        base_addr = '0; start = 1;
        @(negedge clk); #1;
        start = 0;
        c = 0;
        while (!(accepted > a0 && last_acc == 32'h8) && c < 100) begin
            @(negedge clk); #1;
            c++;
        end
        chk("s6_reached_lo", last_acc, 32'h8);
        @(negedge clk);
        #2 reset_n = 0;
        #1;
        chk("s6_rst_busy", busy, 0);
        chk("s6_rst_read", avmm_read, 0);
        chk("s6_rst_count", feat_count, 0);
        chk("s6_rst_error", error, 0);
        chk("s6_rst_guid", feat_guid, 0);
        repeat (2) @(negedge clk);
        #1 reset_n = 1;
        repeat (6) @(negedge clk);
        lat = 1;
        run_walk(0, 200, c);
        chk("s6_latency", c, 22);
        chk("s6_count", feat_count, 3);
        chk("s6_error", error, 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
